// File: rtl/gcd_arb_pkg.sv
// Shared types and constants for the GCD engine round-robin scheduler.
// Latency / backpressure: none; this file holds declarations only.
package gcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 16;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gcd_arbiter_if.sv
// Requester-side bundle: per-requester operand handshakes plus the tagged result.
// Latency / backpressure: wires only; request side is valid/ready, the result is an unthrottled pulse.
interface gcd_arbiter_if
    import gcd_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int IDW = id_w(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_gcd;
    logic                   rsp_err;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping around.
// Latency: purely combinational. Backpressure: none; grant is all-zero when no request is set.
module rr_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDW   = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx
);

    int   idx_k;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx_k     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_k = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx_k]) begin
                found        = 1'b1;
                grant[idx_k] = 1'b1;
                grant_idx    = idx_k[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one subtract-loop GCD engine between N_REQ requesters; optional GCD_ARB_ZERO_BYPASS_EN answers zero operands locally.
// Latency: eng_start at T+1 after accept, response the cycle after done falls (zero operand: T+1).
// Backpressure: one request in flight, req_ready only in IDLE; responses are never stalled.
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    gcd_arbiter_if.slave     bus,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_a,
    output logic [WIDTH-1:0] eng_b,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_gcd,
    output logic             busy
);

    localparam int IDW = id_w(N_REQ);

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr, grant_idx, id_q;
    logic [N_REQ-1:0] grant;
    logic [WIDTH-1:0] sel_a, sel_b, cap_q;
    logic             done_seen, accept, zero_op;

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_a = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_b = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        zero_op       = (sel_a == '0) || (sel_b == '0);
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    bus.req_ready = grant;
                    accept        = 1'b1;
                    state_nxt     = zero_op ? RESP : ISSUE;
                end
            end
            ISSUE: state_nxt = BUSY;
            // Only the falling edge of the done run marks the result as final.
            BUSY:  if (done_seen && !eng_done) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            id_q          <= '0;
            cap_q         <= '0;
            done_seen     <= 1'b0;
            eng_start     <= 1'b0;
            eng_a         <= '0;
            eng_b         <= '0;
            busy          <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_gcd   <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            eng_start     <= 1'b0;
            bus.rsp_valid <= 1'b0;
            busy          <= (state_nxt != IDLE);
            if (accept) begin
                id_q <= grant_idx;
                ptr  <= (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + IDW'(1);
                if (!zero_op) begin
                    eng_start <= 1'b1;
                    eng_a     <= sel_a;
                    eng_b     <= sel_b;
                end
            end
            if (state == ISSUE) done_seen <= 1'b0;
            // Every done-high cycle overwrites the capture; earlier values are stale.
            if (state == BUSY && eng_done) begin
                cap_q     <= eng_gcd;
                done_seen <= 1'b1;
            end
            if (state_nxt == RESP) begin
                bus.rsp_valid <= 1'b1;
                if (state == IDLE) begin
                    bus.rsp_id <= grant_idx;
`ifdef GCD_ARB_ZERO_BYPASS_EN
                    bus.rsp_gcd <= sel_a | sel_b;
                    bus.rsp_err <= 1'b0;
`else
                    bus.rsp_gcd <= '0;
                    bus.rsp_err <= 1'b1;
`endif
                end else begin
                    bus.rsp_id  <= id_q;
                    bus.rsp_gcd <= cap_q;
                    bus.rsp_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural engine and a per-cycle reference model.
module tb_gcd_arbiter;
    import gcd_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    typedef struct {
        int         id;
        logic [W-1:0] gcd;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
    logic         eng_start, eng_done, busy;
    logic [W-1:0] eng_a, eng_b, eng_gcd;

    gcd_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .eng_start (eng_start),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_done  (eng_done),
        .eng_gcd   (eng_gcd),
        .busy      (busy)
    );

    int total = 0;
    int bad = 0;
    int eng_lat = 2;
    int eng_run = 3;
    int rsp_cnt = 0;
    int start_cnt = 0;
    int           grant_log[$];
    int           id_log[$];
    logic [W-1:0] gcd_log[$];
    logic         err_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [W-1:0] gat(input int k);
        return (k < gcd_log.size()) ? gcd_log[k] : 'x;
    endfunction
    function automatic logic eat(input int k);
        return (k < err_log.size()) ? err_log[k] : 1'bx;
    endfunction
    function automatic int iat(input int k);
        return (k < id_log.size()) ? id_log[k] : -1;
    endfunction
    function automatic int grat(input int k);
        return (k < grant_log.size()) ? grant_log[k] : -1;
    endfunction

    // Engine: done held for eng_run cycles, true result only on the last one.
    initial begin : engine
        logic [W-1:0] g;
        eng_done = 1'b0;
        eng_gcd  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && eng_start === 1'b1) begin
                g = ref_gcd(eng_a, eng_b);
                repeat (eng_lat) begin @(posedge clk); #1; end
                for (int k = 0; k < eng_run; k++) begin
                    eng_done = 1'b1;
                    eng_gcd  = (k == eng_run - 1) ? g : '0;
                    @(posedge clk); #1;
                end
                eng_done = 1'b0;
                eng_gcd  = 16'h5A5A;
            end
        end
    end

    // Reference model and per-cycle compare.
    initial begin : compare
        int           mptr, g;
        bit           outst, start_due, rsp_due, prev_done, nstart, nrsp;
        exp_t         q[$];
        exp_t         e;
        logic [W-1:0] la, lb, ea, eb, lgcd;
        int           lid;
        logic         lerr;
        logic [N-1:0] exp_ready;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mptr = 0; outst = 0; start_due = 0; rsp_due = 0; prev_done = 0;
                q.delete();
                ea = '0; eb = '0; lgcd = '0; lid = 0; lerr = 1'b0;
                continue;
            end
            g = outst ? -1 : pick(bus.req_valid, mptr);
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", bus.req_ready, exp_ready);
            chk("busy", busy, outst);
            chk("eng_start", eng_start, start_due);
            chk("rsp_valid", bus.rsp_valid, rsp_due);
            chk("eng_a_hold", eng_a, ea);
            chk("eng_b_hold", eng_b, eb);
            if (eng_start === 1'b1) start_cnt++;
            if (bus.rsp_valid === 1'b1) begin
                rsp_cnt++;
                id_log.push_back(int'(bus.rsp_id));
                gcd_log.push_back(bus.rsp_gcd);
                err_log.push_back(bus.rsp_err);
            end
            if (rsp_due && q.size() > 0) begin
                e = q.pop_front();
                lid = e.id; lgcd = e.gcd; lerr = e.err;
                outst = 0;
            end
            chk("rsp_id", bus.rsp_id, lid);
            chk("rsp_gcd", bus.rsp_gcd, lgcd);
            chk("rsp_err", bus.rsp_err, lerr);
            nstart = 0;
            nrsp   = 0;
            if (outst && prev_done && !eng_done) nrsp = 1;
            if (g >= 0) begin
                la = bus.req_a[g*W +: W];
                lb = bus.req_b[g*W +: W];
                e.id = g;
                if (la == 0 || lb == 0) begin
`ifdef GCD_ARB_ZERO_BYPASS_EN
                    e.gcd = la | lb; e.err = 1'b0;
`else
                    e.gcd = '0; e.err = 1'b1;
`endif
                    nrsp = 1;
                end else begin
                    e.gcd = ref_gcd(la, lb); e.err = 1'b0;
                    nstart = 1;
                    ea = la; eb = lb;
                end
                q.push_back(e);
                outst = 1;
                mptr = (g + 1) % N;
                grant_log.push_back(g);
            end
            prev_done = eng_done;
            start_due = nstart;
            rsp_due   = nrsp;
        end
    end

    task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        bus.req_valid[i]      = 1'b1;
        bus.req_a[i*W +: W]   = a;
        bus.req_b[i*W +: W]   = b;
        acc = 0;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if (bus.req_ready[i]) acc = 1;
        end
        chk("accept", acc, 1);
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        for (int c = 0; c < 400 && rsp_cnt < n; c++) begin
            @(posedge clk); #1;
        end
        chk("rsp_wait", (rsp_cnt >= n), 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_a", eng_a, 0);
        chk("rst_eng_b", eng_b, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_gcd", bus.rsp_gcd, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_req_ready", bus.req_ready, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int base, sc;
        logic [W-1:0] za[3];
        logic [W-1:0] zb[3];
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        #2;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fairness: all four held valid, expect grants 0,1,2,3,0.
        eng_lat = 1; eng_run = 2;
        bus.req_a = {16'd100, 16'd48, 16'd17, 16'd21};
        bus.req_b = {16'd75,  16'd36, 16'd5,  16'd14};
        bus.req_valid = 4'hF;
        wait_rsp(5);
        bus.req_valid = '0;
        chk("fair_g0", grat(0), 0);
        chk("fair_g1", grat(1), 1);
        chk("fair_g2", grat(2), 2);
        chk("fair_g3", grat(3), 3);
        chk("fair_g4", grat(4), 0);
        chk("fair_r0", gat(0), 7);
        chk("fair_r1", gat(1), 1);
        chk("fair_r2", gat(2), 12);
        chk("fair_r3", gat(3), 25);
        chk("fair_id3", iat(3), 3);
        repeat (2) @(posedge clk); #1;

        // Single request.
        base = rsp_cnt; sc = start_cnt;
        eng_lat = 2; eng_run = 3;
        send(0, 16'd12, 16'd8);
        wait_rsp(base + 1);
        chk("single_gcd", gat(base), 4);
        chk("single_id", iat(base), 0);
        chk("single_starts", start_cnt - sc, 1);

        // Long done run: earlier done cycles carry stale zero.
        base = rsp_cnt;
        eng_lat = 1; eng_run = 5;
        send(2, 16'd91, 16'd35);
        wait_rsp(base + 1);
        chk("stale_gcd", gat(base), 7);
        chk("stale_id", iat(base), 2);

        // Zero operands.
        za[0] = 16'd0; zb[0] = 16'd9;
        za[1] = 16'd5; zb[1] = 16'd0;
        za[2] = 16'd0; zb[2] = 16'd0;
        sc = start_cnt;
        for (int k = 0; k < 3; k++) begin
            base = rsp_cnt;
            send(k + 1, za[k], zb[k]);
            wait_rsp(base + 1);
`ifdef GCD_ARB_ZERO_BYPASS_EN
            chk("zero_gcd", gat(base), za[k] | zb[k]);
            chk("zero_err", eat(base), 0);
`else
            chk("zero_gcd", gat(base), 0);
            chk("zero_err", eat(base), 1);
`endif
            chk("zero_id", iat(base), k + 1);
        end
        chk("zero_no_start", start_cnt - sc, 0);

        // Equal operands at full scale.
        base = rsp_cnt;
        eng_lat = 1; eng_run = 2;
        send(2, 16'hFFFF, 16'hFFFF);
        wait_rsp(base + 1);
        chk("equal_gcd", gat(base), 16'hFFFF);

        // Reset while the engine is running.
        base = rsp_cnt;
        eng_lat = 8; eng_run = 3;
        send(3, 16'd30, 16'd12);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_rsp", rsp_cnt, base);

        // Traffic after reset; pointer restarts at 0.
        eng_lat = 1; eng_run = 2;
        send(1, 16'd9, 16'd6);
        wait_rsp(base + 1);
        chk("post_rst_gcd", gat(base), 3);
        chk("post_rst_id", iat(base), 1);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
